// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle control FSM:
// states, opcodes, ALU operations and ALU B-input selects.
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC_R = 3'd2,
    S_EXEC_I = 3'd3,
    S_BRANCH = 3'd4,
    S_WB_R   = 3'd5,
    S_WB_I   = 3'd6
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_SLT   = 3'b011,
    ALU_OR    = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_RT   = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10,
    SRCB_BR   = 2'b11
  } src_b_e;

  // Unsupported opcodes fall back to FETCH.
  function automatic state_e decode_next(input logic [5:0] op);
    state_e nxt;
    case (op)
      OP_R:                     nxt = S_EXEC_R;
      OP_ADDI, OP_SLTI, OP_ORI: nxt = S_EXEC_I;
      OP_BEQ, OP_BNE:           nxt = S_BRANCH;
      default:                  nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_imm_op_decode.sv
// I-type opcode to ALU operation and immediate-extension mode.
module imm_op_decode
  import multicycle_pkg::*;
(
  input  logic [5:0] op_i,
  output alu_op_e    alu_op_o,
  output logic       zext_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    zext_o   = 1'b0;
    case (op_i)
      OP_SLTI: alu_op_o = ALU_SLT;
      OP_ORI: begin
        alu_op_o = ALU_OR;
        zext_o   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the shared-ALU datapath,
// with an instruction-memory handshake and a retire counter.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       op_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             imem_ready_i,
  output logic             imem_req_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             pc_source_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             zext_o,
  output logic             illegal_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e           state_q;
  logic [CNT_W-1:0] retired_q;
  alu_op_e          imm_alu_op;
  logic             imm_zext;
  logic             unused_funct;

  assign unused_funct = ^funct_i;

  imm_op_decode u_imm (
    .op_i     (op_i),
    .alu_op_o (imm_alu_op),
    .zext_o   (imm_zext)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_FETCH:
          if (imem_ready_i) state_q <= S_DECODE;
        S_DECODE: state_q <= decode_next(op_i);
        S_EXEC_R: state_q <= S_WB_R;
        S_EXEC_I: state_q <= S_WB_I;
        S_BRANCH, S_WB_R, S_WB_I: begin
          state_q   <= S_FETCH;
          retired_q <= retired_q + 1'b1;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Outputs decode from state; reset low masks everything.
  always_comb begin
    imem_req_o  = 1'b0;
    ir_write_o  = 1'b0;
    pc_write_o  = 1'b0;
    pc_source_o = 1'b0;
    reg_write_o = 1'b0;
    reg_dst_o   = 1'b0;
    alu_src_a_o = 1'b0;
    alu_src_b_o = SRCB_RT;
    alu_op_o    = ALU_ADD;
    zext_o      = 1'b0;
    illegal_o   = 1'b0;
    if (rst_i) begin
      case (state_q)
        S_FETCH: begin
          imem_req_o  = 1'b1;
          alu_src_b_o = SRCB_FOUR;
          ir_write_o  = imem_ready_i;
          pc_write_o  = imem_ready_i;
        end
        S_DECODE: begin
          alu_src_b_o = SRCB_BR;
          illegal_o   = (decode_next(op_i) == S_FETCH);
        end
        S_EXEC_R: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_FUNCT;
        end
        S_EXEC_I: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRCB_IMM;
          alu_op_o    = imm_alu_op;
          zext_o      = imm_zext;
        end
        S_BRANCH: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_SUB;
          pc_source_o = 1'b1;
          pc_write_o  = ((op_i == OP_BEQ) & zero_i)
                      | ((op_i == OP_BNE) & ~zero_i);
        end
        S_WB_R: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
        end
        S_WB_I: begin
          reg_write_o = 1'b1;
          alu_op_o    = imm_alu_op;
          zext_o      = imm_zext;
        end
        default: ;
      endcase
    end
  end

  assign state_o   = state_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level
// model queues per-cycle expectations, a monitor compares them.
module tb_multicycle_ctrl;

  localparam int CW = 4;

  typedef struct packed {
    logic [2:0]    st;
    logic          req;
    logic          irw;
    logic          pcw;
    logic          pcs;
    logic          rw;
    logic          rd;
    logic          sa;
    logic [1:0]    sb;
    logic [2:0]    aop;
    logic          zx;
    logic          ill;
    logic [CW-1:0] ret;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic [5:0]    op_i = '0;
  logic [5:0]    funct_i = '0;
  logic          zero_i = 1'b0;
  logic          imem_ready_i = 1'b0;
  logic          imem_req_o;
  logic          ir_write_o;
  logic          pc_write_o;
  logic          pc_source_o;
  logic          reg_write_o;
  logic          reg_dst_o;
  logic          alu_src_a_o;
  logic [1:0]    alu_src_b_o;
  logic [2:0]    alu_op_o;
  logic          zext_o;
  logic          illegal_o;
  logic [2:0]    state_o;
  logic [CW-1:0] retired_o;

  exp_t          q[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  logic [CW-1:0] cnt = '0;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .op_i         (op_i),
    .funct_i      (funct_i),
    .zero_i       (zero_i),
    .imem_ready_i (imem_ready_i),
    .imem_req_o   (imem_req_o),
    .ir_write_o   (ir_write_o),
    .pc_write_o   (pc_write_o),
    .pc_source_o  (pc_source_o),
    .reg_write_o  (reg_write_o),
    .reg_dst_o    (reg_dst_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .zext_o       (zext_o),
    .illegal_o    (illegal_o),
    .state_o      (state_o),
    .retired_o    (retired_o)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      a.st  = state_o;
      a.req = imem_req_o;
      a.irw = ir_write_o;
      a.pcw = pc_write_o;
      a.pcs = pc_source_o;
      a.rw  = reg_write_o;
      a.rd  = reg_dst_o;
      a.sa  = alu_src_a_o;
      a.sb  = alu_src_b_o;
      a.aop = alu_op_o;
      a.zx  = zext_o;
      a.ill = illegal_o;
      a.ret = retired_o;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cyc%0d outputs got=%h exp=%h (st %0d/%0d ret %0d/%0d)",
                 cyc, a, e, a.st, e.st, a.ret, e.ret);
      end
    end
  end

  function automatic exp_t mk(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.st  = st;
    e.ret = cnt;
    return e;
  endfunction

  task automatic step(input logic rst, input logic rdy,
                      input logic [5:0] op, input logic z,
                      input exp_t e);
    @(posedge clk);
    #1;
    rst_i        = rst;
    imem_ready_i = rdy;
    op_i         = op;
    zero_i       = z;
    funct_i      = 6'($urandom);
    q.push_back(e);
  endtask

  task automatic fetch(input int waits);
    exp_t e;
    for (int w = 0; w < waits; w++) begin
      e = mk(3'd0);
      e.req = 1'b1;
      e.sb  = 2'b01;
      step(1'b1, 1'b0, 6'($urandom), 1'($urandom), e);
    end
    e = mk(3'd0);
    e.req = 1'b1;
    e.sb  = 2'b01;
    e.irw = 1'b1;
    e.pcw = 1'b1;
    step(1'b1, 1'b1, 6'($urandom), 1'($urandom), e);
  endtask

  task automatic decode(input logic [5:0] op);
    exp_t e;
    bit legal;
    legal = (op == 6'h00) || (op == 6'h08) || (op == 6'h0A)
         || (op == 6'h0D) || (op == 6'h04) || (op == 6'h05);
    e = mk(3'd1);
    e.sb  = 2'b11;
    e.ill = !legal;
    step(1'b1, 1'($urandom), op, 1'($urandom), e);
  endtask

  task automatic instr(input logic [5:0] op, input int waits,
                       input logic z);
    exp_t e;
    logic [2:0] aop;
    logic zx;
    fetch(waits);
    decode(op);
    if (op == 6'h00) begin
      e = mk(3'd2);
      e.sa = 1'b1; e.aop = 3'b010;
      step(1'b1, 1'($urandom), op, 1'($urandom), e);
      e = mk(3'd5);
      e.rw = 1'b1; e.rd = 1'b1;
      step(1'b1, 1'($urandom), op, 1'($urandom), e);
      cnt = cnt + 1'b1;
    end else if (op == 6'h08 || op == 6'h0A || op == 6'h0D) begin
      aop = (op == 6'h08) ? 3'b000 : (op == 6'h0A) ? 3'b011 : 3'b100;
      zx  = (op == 6'h0D);
      e = mk(3'd3);
      e.sa = 1'b1; e.sb = 2'b10; e.aop = aop; e.zx = zx;
      step(1'b1, 1'($urandom), op, 1'($urandom), e);
      e = mk(3'd6);
      e.rw = 1'b1; e.aop = aop; e.zx = zx;
      step(1'b1, 1'($urandom), op, 1'($urandom), e);
      cnt = cnt + 1'b1;
    end else if (op == 6'h04 || op == 6'h05) begin
      e = mk(3'd4);
      e.sa = 1'b1; e.aop = 3'b001; e.pcs = 1'b1;
      e.pcw = (op == 6'h04) ? z : !z;
      step(1'b1, 1'($urandom), op, z, e);
      cnt = cnt + 1'b1;
    end
  endtask

  task automatic reset_cycles(input int n);
    exp_t e;
    cnt = '0;
    for (int k = 0; k < n; k++) begin
      e = mk(3'd0);
      step(1'b0, 1'($urandom), 6'($urandom), 1'($urandom), e);
    end
  endtask

  initial begin
    logic [5:0] ops [7];
    ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h0A;
    ops[3] = 6'h0D; ops[4] = 6'h04; ops[5] = 6'h05;
    ops[6] = 6'h3F;

    reset_cycles(3);
    instr(6'h00, 0, 1'b0);
    instr(6'h04, 0, 1'b1);
    instr(6'h04, 0, 1'b0);
    instr(6'h05, 0, 1'b0);
    instr(6'h05, 1, 1'b1);
    instr(6'h0D, 0, 1'b0);
    instr(6'h08, 2, 1'b0);
    instr(6'h0A, 0, 1'b1);
    instr(6'h00, 3, 1'b0);
    instr(6'h3F, 0, 1'b0);
    instr(6'h00, 0, 1'b0);

    // Abort an R-type in EXEC_R by asserting reset.
    fetch(0);
    decode(6'h00);
    reset_cycles(2);

    for (int n = 0; n < 250; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 6)];
      instr(op, $urandom_range(0, 3), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain left=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
